// File: rtl/stream_ram_pkg.sv
// Shared types and helpers for the stream_ram windowed streaming buffer.
package stream_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // True when [base, base+len) fits inside a memory of 'depth' words.
  // Operands are zero-extended, so the sum cannot wrap.
  function automatic logic window_ok(input logic [31:0] base,
                                     input logic [31:0] len,
                                     input logic [31:0] depth);
    logic [32:0] end_excl;
    end_excl = {1'b0, base} + {1'b0, len};
    return end_excl <= {1'b0, depth};
  endfunction

endpackage

// File: rtl/stream_ram_skid.sv
// Two-entry output buffer with fall-through when empty; occupancy feeds the
// reader's credit check so the registered memory read never overflows it.
module stream_ram_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   occ_q;
  logic         pop;
  logic         push;

  // Valid/ready: a word moves when out_valid & out_ready; while stalled the
  // head entry (or the held memory register when empty) stays unchanged.
  always_comb begin
    out_valid = (occ_q != 2'd0) || in_valid;
    out_data  = (occ_q != 2'd0) ? e0 : in_data;
    pop       = out_valid && out_ready;
    push      = in_valid && !((occ_q == 2'd0) && out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (en) begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            e0    <= in_data;
            occ_q <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && push) begin
            e0 <= in_data;
          end else if (pop) begin
            occ_q <= 2'd0;
          end else if (push) begin
            e1    <= in_data;
            occ_q <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            e0 <= e1;
            if (push) e1 <= in_data;
            else      occ_q <= 2'd1;
          end
        end
      endcase
    end
  end

  assign occ = occ_q;

endmodule

// File: rtl/stream_ram.sv
// Word-addressed buffer with a windowed sequential reader streaming
// [rd_base, rd_base+rd_len) over valid/ready, one-shot or circular.
module stream_ram
  import stream_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 156800,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              rd_circ,
  input  logic              rd_stop,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] cnt;
  logic              circ_q;
  logic              stop_req;
  logic              inflight;
  logic              last_q;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        occ;
  logic [1:0]        pending;
  logic              wr_ok;
  logic              start_ok;
  logic              is_last;
  logic              stop_now;
  logic              issue;
  logic              pop;
  logic              drain_done;

  always_comb begin
    wr_ok      = 32'(wr_addr) < 32'(DEPTH);
    start_ok   = window_ok(32'(rd_base), 32'(rd_len), 32'(DEPTH));
    pending    = occ + {1'b0, inflight};
    pop        = rd_valid && rd_ready;
    is_last    = (cnt == (len_q - ONE));
    stop_now   = circ_q && (stop_req || rd_stop);
    issue      = en && (state_q == ST_RUN) && (pending < 2'd2);
    // DRAIN ends when the last outstanding word leaves this cycle.
    drain_done = (pending == 2'd0) || ((pending == 2'd1) && pop);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_IDLE:  if (rd_start && (rd_len != '0) && start_ok) state_d = ST_RUN;
        ST_RUN:   if (issue && is_last && (!circ_q || stop_now)) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_done) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      circ_q   <= 1'b0;
      rd_ptr   <= '0;
      cnt      <= '0;
      stop_req <= 1'b0;
      inflight <= 1'b0;
      last_q   <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      wr_err  <= 1'b0;
      if (en) begin
        wr_err   <= wr_en && !wr_ok;
        // Whatever was in flight is now either consumed or parked in the skid.
        inflight <= issue;
        if ((state_q == ST_IDLE) && rd_start) begin
          if (rd_len == '0) begin
            done <= 1'b1;
          end else if (!start_ok) begin
            cfg_err <= 1'b1;
          end else begin
            base_q   <= rd_base;
            len_q    <= rd_len;
            circ_q   <= rd_circ;
            rd_ptr   <= rd_base;
            cnt      <= '0;
            stop_req <= 1'b0;
          end
        end
        if ((state_q == ST_RUN) && rd_stop && circ_q) stop_req <= 1'b1;
        if (issue) begin
          last_q <= is_last;
          if (is_last) begin
            rd_ptr <= base_q;
            cnt    <= '0;
          end else begin
            rd_ptr <= rd_ptr + ONE;
            cnt    <= cnt + ONE;
          end
        end
        if ((state_q == ST_DRAIN) && drain_done) done <= 1'b1;
      end
    end
  end

  // Array has no reset; a same-address write lands after this cycle's read.
  always_ff @(posedge clk) begin
    if (en && wr_en && wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        mem_q <= '0;
    else if (issue) mem_q <= mem[rd_ptr];
  end

  stream_ram_skid #(
    .W(int'(DATA_W) + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (inflight),
    .in_data   ({last_q, mem_q}),
    .out_ready (rd_ready),
    .out_valid (rd_valid),
    .out_data  ({rd_last, rd_data}),
    .occ       (occ)
  );

endmodule

// File: tb/tb_stream_ram.sv
// Directed and randomized bench for stream_ram against a word-level model.
module tb_stream_ram;

  localparam int DW    = 16;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_len;
  logic          rd_circ;
  logic          rd_stop;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [1:0]    dbg_state;

  stream_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_circ(rd_circ),
    .rd_stop(rd_stop), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .done(done), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory image plus expected {last, data} beats
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW:0]   exp_q[$];

  int tests = 0;
  int fails = 0;
  int beats, busy_cnt, done_cnt, done_cyc, first_beat_cyc;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every handshake is matched against the model queue
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(rd_valid), 32'd1);
        check("stall_word", 32'({rd_last, rd_data}), 32'(prev_word));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          check("beat", 32'({rd_last, rd_data}), 32'(exp_q.pop_front()));
        end
        beats++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_word  = {rd_last, rd_data};
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < DEPTH) ref_mem[a] = d;
  endtask

  function automatic logic ready_val(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic wait_done(input int sd, input string tag);
    int k = 0;
    while (done_cnt == sd && k < 300) begin
      tick();
      k++;
    end
    check(tag, 32'(done_cnt - sd), 32'd1);
  endtask

  // One window run: model expects 'passes' copies of the window, last tagged
  task automatic run(input int base, input int len, input logic circ, input int mode,
                     input int stop_k, input logic drop_en);
    int passes, n, sd, k;
    passes = circ ? stop_k + 1 : 1;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, ref_mem[base + i]});
    beats = 0; busy_cnt = 0; first_beat_cyc = -1; sd = done_cnt;
    rd_base = AW'(base); rd_len = AW'(len); rd_circ = circ; rd_start = 1'b1;
    rd_ready = ready_val(mode, 0);
    n = cyc;
    tick();
    rd_start = 1'b0;
    k = 1;
    while (done_cnt == sd && k < 3000) begin
      rd_stop  = circ && (beats >= stop_k * len);
      en       = drop_en ? ($urandom_range(0, 9) != 0) : 1'b1;
      rd_ready = en && ready_val(mode, k);
      tick();
      k++;
    end
    check("run_done", 32'(done_cnt - sd), 32'd1);
    check("run_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (mode == 0 && !circ && !drop_en) begin
      check("first_beat_cyc", 32'(first_beat_cyc), 32'(n + 2));
      check("done_cyc", 32'(done_cyc), 32'(n + len + 2));
      check("busy_cycles", 32'(busy_cnt), 32'(len + 1));
    end
    rd_stop = 1'b0; en = 1'b1; rd_ready = 1'b0;
  endtask

  initial begin
    int sd, len, base, nd;
    logic circ;
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_circ = 1'b0; rd_stop = 1'b0; rd_ready = 1'b0;
    beats = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; first_beat_cyc = -1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_last", 32'(rd_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Fill memory: 0x10..0x17 at 0..7, random elsewhere
    for (int i = 0; i < DEPTH; i++)
      write(i, (i < 8) ? DW'(16'h10 + i) : DW'($urandom()));
    @(negedge clk);
    check("wr_err_in_range", 32'(wr_err), 32'd0);
    tick();

    run(2, 4, 1'b0, 0, 0, 1'b0);
    run(2, 4, 1'b0, 1, 0, 1'b0);
    run(5, 3, 1'b1, 0, 1, 1'b0);

    // Zero-length start
    sd = done_cnt;
    rd_base = 7'd10; rd_len = '0; rd_circ = 1'b0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_valid", 32'(rd_valid), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    check("len0_done_pulse", 32'(done), 32'd0);
    tick();

    // Window overflow
    rd_base = AW'(DEPTH - 2); rd_len = 7'd3; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    @(negedge clk);
    check("ovf_cfg_err", 32'(cfg_err), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_done", 32'(done), 32'd0);
    tick();
    @(negedge clk);
    check("ovf_busy2", 32'(busy), 32'd0);
    check("ovf_cfg_err_pulse", 32'(cfg_err), 32'd0);
    tick();
    run(DEPTH - 3, 3, 1'b0, 0, 0, 1'b0);

    // Out-of-range write
    write(DEPTH, 16'hdead);
    @(negedge clk);
    check("wr_err_pulse", 32'(wr_err), 32'd1);
    tick();
    @(negedge clk);
    check("wr_err_clear", 32'(wr_err), 32'd0);
    tick();
    run(DEPTH - 1, 1, 1'b0, 0, 0, 1'b0);
    run(0, 8, 1'b0, 0, 0, 1'b0);

    // Write to address 3 in the cycle its read is issued: old data expected
    nd = int'($urandom_range(0, 65535));
    exp_q.push_back({1'b1, ref_mem[3]});
    sd = done_cnt;
    rd_base = 7'd3; rd_len = 7'd1; rd_circ = 1'b0; rd_ready = 1'b1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    write(3, DW'(nd));
    wait_done(sd, "rdw_done");
    check("rdw_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rd_ready = 1'b0;
    run(3, 1, 1'b0, 0, 0, 1'b0);

    // Reset two cycles into a run
    rd_base = 7'd0; rd_len = 7'd8; rd_circ = 1'b0; rd_ready = 1'b1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    sd = done_cnt;
    repeat (5) tick();
    check("midrst_no_done", 32'(done_cnt - sd), 32'd0);
    rd_ready = 1'b0;
    run(1, 6, 1'b0, 2, 0, 1'b0);

    // Randomized windows, modes, circular stops and enable drops
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1) write(int'($urandom_range(0, DEPTH - 1)), DW'($urandom()));
      circ = 1'($urandom_range(0, 1));
      len  = circ ? int'($urandom_range(3, 12)) : int'($urandom_range(1, 20));
      base = int'($urandom_range(0, DEPTH - len));
      run(base, len, circ, int'($urandom_range(0, 2)), int'($urandom_range(1, 2)),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_ram.md
# stream_ram

Parametrised single-port-write / streaming-read buffer for activation and weight tiles. Host logic writes words by address; a windowed sequential reader then streams a programmed range `[rd_base, rd_base+rd_len)` out over a valid/ready interface, one-shot or circular, with full backpressure. It replaces fixed-size, free-running read-pointer buffers in the accelerator datapath.

## Interface
- `DATA_W`, 16, word width
- `DEPTH`, 156800, number of words
- `ADDR_W`, 18, address width; must satisfy 2^ADDR_W >= DEPTH
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable; low freezes all state, ignores writes and start
- `wr_en`  in  1  write strobe
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `wr_err`  out  1  registered pulse: last write had `wr_addr >= DEPTH` and was dropped
- `rd_start`  in  1  start pulse, sampled only in IDLE
- `rd_base`  in  ADDR_W  window start, sampled with `rd_start`
- `rd_len`  in  ADDR_W  window length in words, sampled with `rd_start`
- `rd_circ`  in  1  1 = circular (repeat window), 0 = one-shot; sampled with `rd_start`
- `rd_stop`  in  1  ends a circular run (see Operation)
- `rd_valid`  out  1  output word valid
- `rd_ready`  in  1  consumer accepts word
- `rd_data`  out  DATA_W  output word
- `rd_last`  out  1  high with the final word of each window pass
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at end of run
- `cfg_err`  out  1  one-cycle pulse: start rejected

## Operation
- Reset values: `rd_valid`, `rd_data`, `rd_last`, `busy`, `done`, `wr_err`, `cfg_err` all 0; state IDLE; skid empty. Memory contents are NOT cleared by reset.
- Writes: when `en & wr_en & wr_addr < DEPTH`, `mem[wr_addr] <= wr_data`. Out-of-range writes dropped, `wr_err` pulses next cycle. Writes allowed in any state.
- Read-during-write to the same address in the same cycle returns OLD data.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on `rd_start` with `rd_len != 0` and `rd_base + rd_len <= DEPTH` (computed at ADDR_W+1 bits). Latch base/len/circ, `rd_ptr <= rd_base`, `cnt <= 0`.
  - IDLE, `rd_start` with `rd_len == 0`: no beats, `done` pulses next cycle, stay IDLE.
  - IDLE, `rd_start` with window overflow: `cfg_err` pulses next cycle, stay IDLE.
  - RUN: issue one read per cycle when credit available (skid occupancy + in-flight < 2). After issuing word `cnt == len-1`: one-shot -> DRAIN; circular -> `rd_ptr <= base`, `cnt <= 0`, continue.
  - RUN, `rd_stop` (circular only; ignored for one-shot): stop issuing after the current pass's last word, then -> DRAIN.
  - DRAIN -> IDLE when skid empty and nothing in flight; `done` pulses that cycle.
- `rd_last` tags the word with `cnt == len-1` of every pass.
- `rd_start` outside IDLE is ignored.
- `rst` mid-run: flush skid, discard in-flight read, return to IDLE; no `done`.

## Timing
- Memory read latency 1 cycle, registered.
- `rd_start` at cycle N -> first read issued N+1 -> `rd_valid` high at N+2.
- Sustained 1 word/cycle with `rd_ready` held high; no bubbles across circular wrap.
- Output handshake: word transfers on `rd_valid & rd_ready`; `rd_data`/`rd_last` stable while `rd_valid & !rd_ready`. Once asserted, `rd_valid` stays high until the handshake.
- One-shot run of L words with `rd_ready` high: `done` at cycle N+L+2, `busy` high N+1 .. N+L+1.
- `en` low: no issue, no pointer/skid/state change, outputs held.

## Structure
- Package `stream_ram_pkg`: state enum (IDLE/RUN/DRAIN) and a `window_ok(base, len, DEPTH)` function.
- Sub-module `stream_ram_skid`: 2-entry output buffer carrying {last, data}, exposing occupancy for credit. Memory array and controller live in the top.

## Test plan
- Write mem[0..7] = 0x10..0x17; start base=2, len=4, one-shot, ready high -> data 0x12,0x13,0x14,0x15 on consecutive cycles from N+2, `rd_last` on 0x15, `done` at N+6.
- Same run with `rd_ready` toggling 1,0,0,1,... -> identical word sequence, no loss or duplication, data stable while stalled.
- Circular base=5, len=3; assert `rd_stop` mid second pass -> 0x15,0x16,0x17,0x15,0x16,0x17, then `done`; `rd_last` on each 0x17.
- Start with len=0 -> `done` at N+1, no `rd_valid`; start base=DEPTH-2, len=3 -> `cfg_err` at N+1, `busy` stays 0.
- Write to `wr_addr=DEPTH` -> `wr_err` pulse, memory unchanged; same-cycle write and read of address 3 -> stream returns old value.
- Assert `rst` two cycles into a run -> next cycle `rd_valid=0`, `busy=0`, no `done`; a new start then streams correctly.
